// File: rtl/mgc_axi4_cmd_master_pkg.sv
// Shared types and helpers for the AXI4 command master.
package mgc_axi4_cmd_master_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // True when an INCR burst starting at addr would run past the next 4 KB page.
  function automatic logic crosses_4k(input logic [11:0] addr, input logic [7:0] len,
                                      input logic [2:0] size);
    logic [16:0] bytes;
    logic [16:0] end_off;
    bytes   = (17'(len) + 17'd1) << size;
    end_off = 17'(addr) + bytes;
    return end_off > 17'd4096;
  endfunction

endpackage

// File: rtl/mgc_axi4_len_fifo.sv
// Synchronous FIFO of write-burst lengths; the head drives WLAST generation.
module mgc_axi4_len_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mgc_axi4_cmd_master.sv
// AXI4 master turning a command/data stream into read and write bursts.
// Optional illegal-burst rejection: define AXI4_CMD_MASTER_BURST_CHECK_EN.
module mgc_axi4_cmd_master
  import mgc_axi4_cmd_master_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  output logic                    cmd_err,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]              rd_resp,
  output logic                    rd_last,
  output logic [ID_WIDTH-1:0]     rd_id,
  output logic                    wrsp_valid,
  input  logic                    wrsp_ready,
  output logic [1:0]              wrsp_resp,
  output logic [ID_WIDTH-1:0]     wrsp_id,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic [2:0]              AWPROT,
  output logic [3:0]              AWCACHE,
  output logic [3:0]              AWQOS,
  output logic [3:0]              AWREGION,
  output logic                    AWLOCK,
  output logic                    AWUSER,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WUSER,
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  input  logic [ID_WIDTH-1:0]     BID,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic [ID_WIDTH-1:0]     ARID,
  output logic [2:0]              ARPROT,
  output logic [3:0]              ARCACHE,
  output logic [3:0]              ARQOS,
  output logic [3:0]              ARREGION,
  output logic                    ARLOCK,
  output logic                    ARUSER,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic [ID_WIDTH-1:0]     RID
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [7:0]    beat_cnt;
  logic          aw_vld_p1;
  logic          ar_vld_p1;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          wr_room;
  logic          rd_room;
  logic          cmd_acc;
  logic          cmd_legal;
  logic          wr_acc;
  logic          rd_acc;
  logic          aw_hs;
  logic          ar_hs;
  logic          w_hs;
  logic          b_hs;
  logic          r_done;

  // A slot frees when the holding register handshakes this cycle, so commands stream at one per cycle.
  assign wr_room   = (wr_cnt < CW'(MAX_OUTSTANDING)) & (~aw_vld_p1 | AWREADY) & ~fifo_full;
  assign rd_room   = (rd_cnt < CW'(MAX_OUTSTANDING)) & (~ar_vld_p1 | ARREADY);
  assign cmd_ready = cmd_write ? wr_room : rd_room;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign wr_acc    = cmd_acc & cmd_write & cmd_legal;
  assign rd_acc    = cmd_acc & ~cmd_write & cmd_legal;

  assign aw_hs  = aw_vld_p1 & AWREADY;
  assign ar_hs  = ar_vld_p1 & ARREADY;
  assign w_hs   = WVALID & WREADY;
  assign b_hs   = BVALID & BREADY;
  assign r_done = RVALID & RREADY & RLAST;

`ifdef AXI4_CMD_MASTER_BURST_CHECK_EN
  logic err_p1;

  always_comb begin
    cmd_legal = 1'b1;
    case (cmd_burst)
      BURST_INCR: cmd_legal = ~crosses_4k(cmd_addr[11:0], cmd_len, cmd_size);
      BURST_WRAP: cmd_legal = (cmd_len == 8'd1) | (cmd_len == 8'd3) |
                              (cmd_len == 8'd7) | (cmd_len == 8'd15);
      BURST_FIXED: cmd_legal = 1'b1;
      default:    cmd_legal = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) err_p1 <= 1'b0;
    else        err_p1 <= cmd_acc & ~cmd_legal;
  end

  assign cmd_err = err_p1;
`else
  assign cmd_legal = 1'b1;
  assign cmd_err   = 1'b0;
`endif

  // Address holding registers: valid is control, descriptor fields are data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_vld_p1 <= 1'b0;
      ar_vld_p1 <= 1'b0;
    end else begin
      if (wr_acc)     aw_vld_p1 <= 1'b1;
      else if (aw_hs) aw_vld_p1 <= 1'b0;
      if (rd_acc)     ar_vld_p1 <= 1'b1;
      else if (ar_hs) ar_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_acc) begin
      AWADDR  <= cmd_addr;
      AWLEN   <= cmd_len;
      AWSIZE  <= cmd_size;
      AWBURST <= cmd_burst;
      AWID    <= cmd_id;
    end
    if (rd_acc) begin
      ARADDR  <= cmd_addr;
      ARLEN   <= cmd_len;
      ARSIZE  <= cmd_size;
      ARBURST <= cmd_burst;
      ARID    <= cmd_id;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
    end else begin
      case ({wr_acc, b_hs && (wr_cnt != '0)})
        2'b10:   wr_cnt <= wr_cnt + CW'(1);
        2'b01:   wr_cnt <= wr_cnt - CW'(1);
        default: wr_cnt <= wr_cnt;
      endcase
      case ({rd_acc, r_done && (rd_cnt != '0)})
        2'b10:   rd_cnt <= rd_cnt + CW'(1);
        2'b01:   rd_cnt <= rd_cnt - CW'(1);
        default: rd_cnt <= rd_cnt;
      endcase
      if (w_hs) beat_cnt <= WLAST ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  mgc_axi4_len_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_len_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (wr_acc),
    .pop   (w_hs & WLAST),
    .din   (cmd_len),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Write data may run ahead of AW; it is gated only by a known burst length.
  assign AWVALID  = aw_vld_p1;
  assign ARVALID  = ar_vld_p1;
  assign WVALID   = wr_valid & ~fifo_empty;
  assign wr_ready = WREADY & ~fifo_empty;
  assign WLAST    = (beat_cnt == fifo_head);
  assign WDATA    = wr_data;
  assign WSTRB    = wr_strb;

  assign wrsp_valid = BVALID;
  assign wrsp_resp  = BRESP;
  assign wrsp_id    = BID;
  assign BREADY     = wrsp_ready;

  assign rd_valid = RVALID;
  assign rd_data  = RDATA;
  assign rd_resp  = RRESP;
  assign rd_last  = RLAST;
  assign rd_id    = RID;
  assign RREADY   = rd_ready;

  assign AWPROT   = '0;
  assign AWCACHE  = '0;
  assign AWQOS    = '0;
  assign AWREGION = '0;
  assign AWLOCK   = 1'b0;
  assign AWUSER   = 1'b0;
  assign WUSER    = 1'b0;
  assign ARPROT   = '0;
  assign ARCACHE  = '0;
  assign ARQOS    = '0;
  assign ARREGION = '0;
  assign ARLOCK   = 1'b0;
  assign ARUSER   = 1'b0;

endmodule

// File: tb/tb_mgc_axi4_cmd_master.sv
// Directed bench for mgc_axi4_cmd_master (MAX_OUTSTANDING=2).
module tb_mgc_axi4_cmd_master;
  import mgc_axi4_cmd_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic ARESET;
  logic cmd_valid, cmd_ready, cmd_write, cmd_err;
  logic [AW-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [2:0] cmd_size;
  logic [1:0] cmd_burst;
  logic [IW-1:0] cmd_id;
  logic wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [DW/8-1:0] wr_strb;
  logic rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic [1:0] rd_resp;
  logic [IW-1:0] rd_id;
  logic wrsp_valid, wrsp_ready;
  logic [1:0] wrsp_resp;
  logic [IW-1:0] wrsp_id;
  logic AWVALID, AWREADY, AWLOCK, AWUSER;
  logic [AW-1:0] AWADDR;
  logic [7:0] AWLEN;
  logic [2:0] AWSIZE, AWPROT;
  logic [1:0] AWBURST;
  logic [IW-1:0] AWID;
  logic [3:0] AWCACHE, AWQOS, AWREGION;
  logic WVALID, WREADY, WLAST, WUSER;
  logic [DW-1:0] WDATA;
  logic [DW/8-1:0] WSTRB;
  logic BVALID, BREADY;
  logic [1:0] BRESP;
  logic [IW-1:0] BID;
  logic ARVALID, ARREADY, ARLOCK, ARUSER;
  logic [AW-1:0] ARADDR;
  logic [7:0] ARLEN;
  logic [2:0] ARSIZE, ARPROT;
  logic [1:0] ARBURST;
  logic [IW-1:0] ARID;
  logic [3:0] ARCACHE, ARQOS, ARREGION;
  logic RVALID, RREADY, RLAST;
  logic [DW-1:0] RDATA;
  logic [1:0] RRESP;
  logic [IW-1:0] RID;

  int n_cmp = 0;
  int n_bad = 0;

  mgc_axi4_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(2)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .cmd_id(cmd_id), .cmd_err(cmd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
    .rd_last(rd_last), .rd_id(rd_id),
    .wrsp_valid(wrsp_valid), .wrsp_ready(wrsp_ready), .wrsp_resp(wrsp_resp), .wrsp_id(wrsp_id),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID), .AWPROT(AWPROT),
    .AWCACHE(AWCACHE), .AWQOS(AWQOS), .AWREGION(AWREGION), .AWLOCK(AWLOCK), .AWUSER(AWUSER),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID), .ARPROT(ARPROT),
    .ARCACHE(ARCACHE), .ARQOS(ARQOS), .ARREGION(ARREGION), .ARLOCK(ARLOCK), .ARUSER(ARUSER),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = 3'd2;
    cmd_burst = BURST_INCR; cmd_id = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '1; rd_ready = 0; wrsp_ready = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = RESP_OKAY; BID = '0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = RESP_OKAY; RLAST = 0; RID = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESET = 1;
    step();
    step();
    ARESET = 0;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [7:0] l,
                       input logic [IW-1:0] id);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
    cmd_size = 3'd2; cmd_burst = BURST_INCR;
  endtask

  task automatic test_reset();
    do_reset();
    cmd_write = 1; wr_valid = 1;
    #1;
    n_cmp++; if (AWVALID !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid got %0b want 0", AWVALID); end
    n_cmp++; if (ARVALID !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid got %0b want 0", ARVALID); end
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_err got %0b want 0", cmd_err); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready_wr got %0b want 1", cmd_ready); end
    n_cmp++; if (WVALID !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid_fifo_empty got %0b want 0", WVALID); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ready got %0b want 0", wr_ready); end
    cmd_write = 0; wr_valid = 0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready_rd got %0b want 1", cmd_ready); end
    n_cmp++; if (dut.wr_cnt !== 2'd0 || dut.rd_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_counters got %0d/%0d want 0/0", dut.wr_cnt, dut.rd_cnt); end
  endtask

  task automatic test_write_basic();
    do_reset();
    AWREADY = 1; WREADY = 1;
    issue(1'b1, 32'h100, 8'd3, 4'd5);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wb_cmd_ready got %0b want 1", cmd_ready); end
    n_cmp++; if (AWVALID !== 1'b0) begin n_bad++; $display("FAIL wb_awvalid_pre got %0b want 0", AWVALID); end
    step();
    cmd_valid = 0;
    n_cmp++; if ({AWVALID, AWADDR, AWLEN, AWSIZE, AWID} !== {1'b1, 32'h100, 8'd3, 3'd2, 4'd5}) begin
      n_bad++; $display("FAIL wb_aw got v=%0b a=%0h l=%0d s=%0d id=%0d want v=1 a=100 l=3 s=2 id=5",
                        AWVALID, AWADDR, AWLEN, AWSIZE, AWID); end
    step();
    n_cmp++; if (AWVALID !== 1'b0) begin n_bad++; $display("FAIL wb_aw_drop got %0b want 0", AWVALID); end
    wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hA0 + i;
      #1;
      n_cmp++; if ({WVALID, wr_ready, WLAST, WDATA} !== {1'b1, 1'b1, (i == 3), 32'hA0 + i}) begin
        n_bad++; $display("FAIL wb_beat%0d got v=%0b r=%0b last=%0b d=%0h want v=1 r=1 last=%0b d=%0h",
                          i, WVALID, wr_ready, WLAST, WDATA, (i == 3), 32'hA0 + i); end
      step();
    end
    n_cmp++; if (WVALID !== 1'b0) begin n_bad++; $display("FAIL wb_w_done got %0b want 0", WVALID); end
    wr_valid = 0;
    n_cmp++; if (dut.wr_cnt !== 2'd1) begin n_bad++; $display("FAIL wb_cnt_before_b got %0d want 1", dut.wr_cnt); end
    BVALID = 1; BID = 4'd5; BRESP = RESP_OKAY; wrsp_ready = 1;
    #1;
    n_cmp++; if ({wrsp_valid, wrsp_id, wrsp_resp, BREADY} !== {1'b1, 4'd5, 2'b00, 1'b1}) begin
      n_bad++; $display("FAIL wb_bresp got v=%0b id=%0d resp=%0d bready=%0b want 1 5 0 1",
                        wrsp_valid, wrsp_id, wrsp_resp, BREADY); end
    step();
    BVALID = 0;
    n_cmp++; if (dut.wr_cnt !== 2'd0) begin n_bad++; $display("FAIL wb_cnt_after_b got %0d want 0", dut.wr_cnt); end
  endtask

  task automatic test_outstanding_reads();
    do_reset();
    ARREADY = 1;
    issue(1'b0, 32'h200, 8'd1, 4'd1);
    step();
    cmd_addr = 32'h300; cmd_id = 4'd2;
    step();
    cmd_addr = 32'h400; cmd_id = 4'd3;
    n_cmp++; if (dut.rd_cnt !== 2'd2) begin n_bad++; $display("FAIL or_cnt_full got %0d want 2", dut.rd_cnt); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL or_third_blocked got %0b want 0", cmd_ready); end
    step();
    step();
    n_cmp++; if ({cmd_ready, ARVALID} !== 2'b00) begin n_bad++; $display("FAIL or_still_blocked got rdy=%0b arv=%0b want 0 0", cmd_ready, ARVALID); end
    RVALID = 1; RID = 4'd1; RDATA = 32'h1111; RLAST = 0; rd_ready = 1;
    #1;
    n_cmp++; if ({rd_valid, RREADY, rd_data, rd_id, cmd_ready} !== {1'b1, 1'b1, 32'h1111, 4'd1, 1'b0}) begin
      n_bad++; $display("FAIL or_rbeat0 got v=%0b rr=%0b d=%0h id=%0d rdy=%0b want 1 1 1111 1 0",
                        rd_valid, RREADY, rd_data, rd_id, cmd_ready); end
    step();
    RDATA = 32'h2222; RLAST = 1;
    #1;
    n_cmp++; if ({rd_last, cmd_ready} !== 2'b10) begin n_bad++; $display("FAIL or_rlast got last=%0b rdy=%0b want 1 0", rd_last, cmd_ready); end
    step();
    RVALID = 0; RLAST = 0;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL or_freed got %0b want 1", cmd_ready); end
    step();
    cmd_valid = 0;
    n_cmp++; if ({ARVALID, ARADDR, ARID, dut.rd_cnt} !== {1'b1, 32'h400, 4'd3, 2'd2}) begin
      n_bad++; $display("FAIL or_third_issued got v=%0b a=%0h id=%0d cnt=%0d want 1 400 3 2",
                        ARVALID, ARADDR, ARID, dut.rd_cnt); end
  endtask

  task automatic test_w_before_aw();
    do_reset();
    WREADY = 1;
    issue(1'b1, 32'h340, 8'd1, 4'd2);
    step();
    cmd_valid = 0;
    wr_valid = 1; wr_data = 32'h55;
    #1;
    n_cmp++; if ({AWVALID, WVALID, WLAST} !== 3'b110) begin n_bad++; $display("FAIL wa_beat0 got aw=%0b w=%0b last=%0b want 1 1 0", AWVALID, WVALID, WLAST); end
    step();
    wr_data = 32'h66;
    #1;
    n_cmp++; if ({WVALID, WLAST, WDATA} !== {1'b1, 1'b1, 32'h66}) begin n_bad++; $display("FAIL wa_beat1 got w=%0b last=%0b d=%0h want 1 1 66", WVALID, WLAST, WDATA); end
    step();
    wr_valid = 0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({AWVALID, AWADDR} !== {1'b1, 32'h340}) begin
        n_bad++; $display("FAIL wa_hold%0d got v=%0b a=%0h want 1 340", i, AWVALID, AWADDR); end
      step();
    end
    AWREADY = 1;
    step();
    n_cmp++; if ({AWVALID, dut.wr_cnt} !== {1'b0, 2'd1}) begin n_bad++; $display("FAIL wa_aw_done got v=%0b cnt=%0d want 0 1", AWVALID, dut.wr_cnt); end
  endtask

  task automatic test_accept_with_b();
    do_reset();
    AWREADY = 1; WREADY = 1;
    issue(1'b1, 32'h400, 8'd0, 4'd1);
    step();
    cmd_valid = 0; wr_valid = 1;
    #1;
    n_cmp++; if (WLAST !== 1'b1) begin n_bad++; $display("FAIL ab_single_wlast got %0b want 1", WLAST); end
    step();
    wr_valid = 0;
    n_cmp++; if (dut.wr_cnt !== 2'd1) begin n_bad++; $display("FAIL ab_cnt_pre got %0d want 1", dut.wr_cnt); end
    issue(1'b1, 32'h500, 8'd0, 4'd3);
    BVALID = 1; BID = 4'd1; wrsp_ready = 1;
    #1;
    n_cmp++; if ({cmd_ready, wrsp_valid} !== 2'b11) begin n_bad++; $display("FAIL ab_both got rdy=%0b bv=%0b want 1 1", cmd_ready, wrsp_valid); end
    step();
    cmd_valid = 0; BVALID = 0;
    n_cmp++; if ({dut.wr_cnt, AWVALID, AWADDR} !== {2'd1, 1'b1, 32'h500}) begin
      n_bad++; $display("FAIL ab_cnt_same got cnt=%0d v=%0b a=%0h want 1 1 500", dut.wr_cnt, AWVALID, AWADDR); end
  endtask

  task automatic test_burst_check();
    do_reset();
    issue(1'b1, 32'hFF0, 8'd7, 4'd4);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL bc_ready got %0b want 1", cmd_ready); end
    step();
    cmd_valid = 0;
`ifdef AXI4_CMD_MASTER_BURST_CHECK_EN
    wr_valid = 1;
    #1;
    n_cmp++; if ({cmd_err, AWVALID, WVALID, dut.wr_cnt} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_bad++; $display("FAIL bc_reject got err=%0b aw=%0b w=%0b cnt=%0d want 1 0 0 0", cmd_err, AWVALID, WVALID, dut.wr_cnt); end
    step();
    wr_valid = 0;
    n_cmp++; if ({cmd_err, AWVALID} !== 2'b00) begin n_bad++; $display("FAIL bc_pulse_end got err=%0b aw=%0b want 0 0", cmd_err, AWVALID); end
`else
    n_cmp++; if ({cmd_err, AWVALID, AWADDR, AWLEN, dut.wr_cnt} !== {1'b0, 1'b1, 32'hFF0, 8'd7, 2'd1}) begin
      n_bad++; $display("FAIL bc_issue got err=%0b v=%0b a=%0h l=%0d cnt=%0d want 0 1 ff0 7 1",
                        cmd_err, AWVALID, AWADDR, AWLEN, dut.wr_cnt); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    WREADY = 1;
    issue(1'b1, 32'h600, 8'd3, 4'd6);
    step();
    cmd_valid = 0; wr_valid = 1;
    step();
    step();
    ARESET = 1;
    step();
    cmd_write = 1;
    #1;
    n_cmp++; if ({AWVALID, WVALID, cmd_ready} !== 3'b001) begin
      n_bad++; $display("FAIL rm_state got aw=%0b w=%0b rdy=%0b want 0 0 1", AWVALID, WVALID, cmd_ready); end
    n_cmp++; if ({dut.wr_cnt, dut.beat_cnt} !== {2'd0, 8'd0}) begin
      n_bad++; $display("FAIL rm_counters got cnt=%0d beat=%0d want 0 0", dut.wr_cnt, dut.beat_cnt); end
    ARESET = 0; wr_valid = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_outstanding_reads();
    test_w_before_aw();
    test_accept_with_b();
    test_burst_check();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mgc_axi4_cmd_master.md
# mgc_axi4_cmd_master

Synthesizable, parametrised AXI4 master engine that turns a simple command/data stream interface into AXI4 read and write bursts on ACLK. It sits between an emulation-side transactor (or DUT-side initiator) and an mgc_axi4_signal_if pin bundle. It tracks outstanding bursts per direction, generates WLAST itself, and optionally rejects illegal bursts before they reach the bus.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, read and write data width (8..1024, power of 2)
- ID_WIDTH, 4, AXI ID width
- MAX_OUTSTANDING, 4, maximum in-flight bursts per direction (1..16)
- ACLK  in  1  clock, all logic rising-edge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in/out  1/1  command handshake
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr / cmd_len / cmd_size / cmd_burst / cmd_id  in  ADDR_WIDTH/8/3/2/ID_WIDTH  burst descriptor (AXI encoding)
- cmd_err  out  1  one-cycle pulse: command rejected (config-dependent)
- wr_valid / wr_ready  in/out  1/1  write data handshake
- wr_data / wr_strb  in  DATA_WIDTH/DATA_WIDTH/8  write beat
- rd_valid / rd_ready  out/in  1/1  read data handshake
- rd_data / rd_resp / rd_last / rd_id  out  DATA_WIDTH/2/1/ID_WIDTH  read beat
- wrsp_valid / wrsp_ready  out/in  1/1  write response handshake
- wrsp_resp / wrsp_id  out  2/ID_WIDTH  write response
- AWVALID AWADDR AWLEN AWSIZE AWBURST AWID out, AWREADY in: AXI write-address channel
- WVALID WDATA WSTRB WLAST out, WREADY in: AXI write-data channel
- BVALID BRESP BID in, BREADY out: AXI write-response channel
- ARVALID ARADDR ARLEN ARSIZE ARBURST ARID out, ARREADY in: AXI read-address channel
- RVALID RDATA RRESP RLAST RID in, RREADY out: AXI read-data channel
- AWPROT AWCACHE AWQOS AWREGION AWLOCK AWUSER WUSER, AR equivalents: out, constant 0

## Operation
- Per-direction outstanding counters wr_cnt, rd_cnt, width $clog2(MAX_OUTSTANDING+1).
- cmd_ready (write) = wr_cnt < MAX_OUTSTANDING and AW holding register empty or handshaking this cycle and length FIFO not full; read analogue with rd_cnt/AR register. cmd_ready may depend on cmd_write.
- Accept: load AW (or AR) holding register, increment counter; write also pushes cmd_len into length FIFO (depth MAX_OUTSTANDING).
- AWVALID/ARVALID held until AWREADY/ARREADY; fields stable while valid.
- W path combinational: WVALID = wr_valid & FIFO non-empty; wr_ready = WREADY & FIFO non-empty; WLAST = (beat_cnt == FIFO head). Last-beat handshake pops FIFO, clears beat_cnt. W beats may precede AW handshake.
- B: wrsp_* = B*, BREADY = wrsp_ready; wr_cnt decrements on B handshake.
- R: rd_* = R*, RREADY = rd_ready; rd_cnt decrements on RLAST handshake.
- Simultaneous accept and completion in one direction: counter unchanged.
- Reset mid-burst: all state cleared, in-flight bursts abandoned; system reset must cover the slave.

## Timing
- Reset values: AWVALID=ARVALID=0, cmd_err=0, counters 0, FIFO empty, beat_cnt 0; cmd_ready=1 after reset if MAX_OUTSTANDING>=1.
- Command accept to AWVALID/ARVALID: 1 cycle.
- Back-to-back commands same direction: one per cycle while AWREADY/ARREADY held high.
- W, B, R paths: 0-cycle combinational pass-through.

## Configuration
- AXI4_CMD_MASTER_BURST_CHECK_EN defined: accepted command with INCR crossing a 4 KB boundary (addr[11:0] + (len+1)<<size > 4096), WRAP with len not in {1,3,7,15}, or burst=2'b11 is dropped: cmd_err pulses the next cycle, no AXI traffic, no counter/FIFO update; write data for it is not consumed.
- Not defined: no checks, cmd_err tied 0, all commands issued as given.

## Structure
- Package mgc_axi4_cmd_master_pkg: burst_t (FIXED/INCR/WRAP), resp_t (OKAY/EXOKAY/SLVERR/DECERR), function crosses_4k(addr, len, size).
- Sub-module mgc_axi4_len_fifo: synchronous FIFO of 8-bit lengths, parameter DEPTH, push/pop/full/empty/head.

## Test plan
- Write addr 0x100, len 3, size 2, AWREADY=1 -> AWVALID 1 cycle after accept, 4 W beats, WLAST on 4th only; BRESP OKAY -> wrsp_valid, wr_cnt 1->0.
- MAX_OUTSTANDING=2, 3 reads, no RVALID -> third cmd_ready=0 until first RLAST handshake, then accepted.
- Write data before AW with AWREADY=0 for 10 cycles -> W beats complete, AWVALID held with stable AWADDR.
- Accept write same cycle as B handshake at wr_cnt=MAX_OUTSTANDING-1 -> wr_cnt unchanged.
- With AXI4_CMD_MASTER_BURST_CHECK_EN: INCR addr 0xFF0, len 7, size 2 -> cmd_err pulse, AWVALID stays 0; without: burst issued.
- ARESET asserted mid write burst -> next cycle AWVALID=0, FIFO empty, cmd_ready=1.
